bp_resolve_queue: RTL and testbench

In-order queue of in-flight branch predictions that sits directly downstream of `two_level_branch_predictor`. Each fetched branch's IP, predicted direction and the 8-bit history used to predict it are held until execute resolves the branch. On resolution the queue emits a one-cycle update beat that carries the actual outcome, which drives the predictor's `input_taken`, and it flags a mispredict. A mispredict or an external flush discards all younger entries.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_resolve_queue_if.sv | 40 ++++
 rtl/bp_queue_ram.sv | 24 ++
 rtl/bp_resolve_queue.sv | 152 +++++++++++++++
 tb/tb_bp_resolve_queue.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction types: entry layout and queue operation codes.
// Also used by the predictor wrapper.
package bp_pkg;

  localparam int unsigned BP_IP_W   = 64;
  localparam int unsigned BP_HIST_W = 8;

  typedef struct packed {
    logic [BP_IP_W-1:0]   ip;
    logic                 pred;
    logic [BP_HIST_W-1:0] hist;
  } bp_entry_t;

  typedef enum logic [2:0] {
    Q_IDLE,
    Q_PUSH,
    Q_POP,
    Q_PUSH_POP,
    Q_MISPREDICT,
    Q_FLUSH
  } bp_q_op_e;

  function automatic logic bp_is_mispredict(input bp_entry_t e, input logic taken);
    return e.pred ^ taken;
  endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute/predictor-facing signals of the branch resolve queue.
// The master side drives push/resolve/flush; the slave side is the queue.
interface bp_resolve_queue_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IP_W   = 64,
  parameter int unsigned HIST_W = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              push_valid;
  logic              push_ready;
  logic [IP_W-1:0]   push_ip;
  logic              push_pred;
  logic [HIST_W-1:0] push_hist;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              flush;
  logic              upd_valid;
  logic [IP_W-1:0]   upd_ip;
  logic              upd_taken;
  logic [HIST_W-1:0] upd_hist;
  logic              upd_mispredict;
  logic [CW-1:0]     count;
  logic              err_underflow;

  modport master (
    output push_valid, push_ip, push_pred, push_hist,
    output resolve_valid, resolve_taken, flush,
    input  push_ready, upd_valid, upd_ip, upd_taken, upd_hist,
    input  upd_mispredict, count, err_underflow
  );

  modport slave (
    input  push_valid, push_ip, push_pred, push_hist,
    input  resolve_valid, resolve_taken, flush,
    output push_ready, upd_valid, upd_ip, upd_taken, upd_hist,
    output upd_mispredict, count, err_underflow
  );

endinterface

// File: rtl/bp_queue_ram.sv
// Entry storage for the resolve queue: one synchronous write port (tail)
// and one asynchronous read port (head). No reset; validity is tracked by count.
module bp_queue_ram
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  bp_entry_t                i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output bp_entry_t                o_rdata
);

  bp_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight branch predictions; emits a registered update
// beat on each resolve and discards younger entries on mispredict or flush.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IP_W   = BP_IP_W,
  parameter int unsigned HIST_W = BP_HIST_W
) (
  input  logic              clk,
  input  logic              reset_n,
  bp_resolve_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_upd_valid;
  logic [IP_W-1:0]   r_upd_ip;
  logic              r_upd_taken;
  logic [HIST_W-1:0] r_upd_hist;
  logic              r_upd_misp;
  logic              r_err;

  bp_entry_t     w_head_entry;
  bp_entry_t     w_wr_entry;
  logic          w_push_acc;
  logic          w_res_acc;
  logic          w_misp;
  logic          w_we;
  bp_q_op_e      w_op;
  logic [AW-1:0] w_head_inc;
  logic [AW-1:0] w_tail_inc;
  logic [AW-1:0] w_head_nxt;
  logic [AW-1:0] w_tail_nxt;
  logic [CW-1:0] w_count_nxt;

  assign bus.push_ready = (r_count != FULL);

  assign w_push_acc = bus.push_valid && bus.push_ready;
  assign w_res_acc  = bus.resolve_valid && (r_count != '0);
  assign w_misp     = w_res_acc && bp_is_mispredict(w_head_entry, bus.resolve_taken);
  assign w_head_inc = r_head + AW'(1);
  assign w_tail_inc = r_tail + AW'(1);

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.ip   = BP_IP_W'(bus.push_ip);
    w_wr_entry.pred = bus.push_pred;
    w_wr_entry.hist = BP_HIST_W'(bus.push_hist);
  end

  bp_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_tail),
    .i_wdata (w_wr_entry),
    .i_raddr (r_head),
    .o_rdata (w_head_entry)
  );

  // Flush outranks mispredict, which outranks any ordinary push/pop.
  always_comb begin
    w_op = Q_IDLE;
    if (bus.flush)                  w_op = Q_FLUSH;
    else if (w_misp)                w_op = Q_MISPREDICT;
    else if (w_push_acc && w_res_acc) w_op = Q_PUSH_POP;
    else if (w_push_acc)            w_op = Q_PUSH;
    else if (w_res_acc)             w_op = Q_POP;
  end

  always_comb begin
    w_we        = 1'b0;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    case (w_op)
      Q_FLUSH: begin
        w_head_nxt  = '0;
        w_tail_nxt  = '0;
        w_count_nxt = '0;
      end
      Q_MISPREDICT: begin
        w_head_nxt  = w_head_inc;
        w_tail_nxt  = w_head_inc;
        w_count_nxt = '0;
      end
      Q_PUSH_POP: begin
        w_we       = 1'b1;
        w_head_nxt = w_head_inc;
        w_tail_nxt = w_tail_inc;
      end
      Q_PUSH: begin
        w_we        = 1'b1;
        w_tail_nxt  = w_tail_inc;
        w_count_nxt = r_count + CW'(1);
      end
      Q_POP: begin
        w_head_nxt  = w_head_inc;
        w_count_nxt = r_count - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_upd_valid <= 1'b0;
      r_upd_ip    <= '0;
      r_upd_taken <= 1'b0;
      r_upd_hist  <= '0;
      r_upd_misp  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_upd_valid <= w_res_acc && !bus.flush;
      if (w_res_acc && !bus.flush) begin
        r_upd_ip    <= IP_W'(w_head_entry.ip);
        r_upd_taken <= bus.resolve_taken;
        r_upd_hist  <= HIST_W'(w_head_entry.hist);
        r_upd_misp  <= w_misp;
      end
      if (!bus.flush && bus.resolve_valid && (r_count == '0)) r_err <= 1'b1;
    end
  end

  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_ip         = r_upd_ip;
  assign bus.upd_taken      = r_upd_taken;
  assign bus.upd_hist       = r_upd_hist;
  assign bus.upd_mispredict = r_upd_misp;
  assign bus.count          = r_count;
  assign bus.err_underflow  = r_err;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench for bp_resolve_queue: a behavioural FIFO model predicts
// every update beat, occupancy and the sticky underflow flag.
module tb_bp_resolve_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [63:0] ip;
    logic        pred;
    logic [7:0]  hist;
  } m_ent_t;

  typedef struct {
    logic [63:0] ip;
    logic        taken;
    logic [7:0]  hist;
    logic        misp;
  } m_upd_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  bp_resolve_queue_if #(.DEPTH(DEPTH), .IP_W(64), .HIST_W(8)) bus ();

  bp_resolve_queue #(.DEPTH(DEPTH), .IP_W(64), .HIST_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  m_ent_t mq[$];
  m_upd_t exp_q[$];
  logic   m_err = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic idle_inputs();
    bus.push_valid    = 1'b0;
    bus.push_ip       = '0;
    bus.push_pred     = 1'b0;
    bus.push_hist     = '0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
  endtask

  // One clock of stimulus; the model is advanced and the DUT compared after the edge.
  task automatic cycle(input logic pv, input logic [63:0] ip, input logic pr,
                       input logic [7:0] hs, input logic rv, input logic tk,
                       input logic fl);
    logic   pacc, racc, exp_v;
    m_ent_t e;
    m_upd_t x;
    bus.push_valid    = pv;
    bus.push_ip       = ip;
    bus.push_pred     = pr;
    bus.push_hist     = hs;
    bus.resolve_valid = rv;
    bus.resolve_taken = tk;
    bus.flush         = fl;
    #1;
    checks++;
    if (bus.push_ready !== (mq.size() != DEPTH)) begin
      errors++;
      $display("FAIL push_ready: got %b want %b", bus.push_ready, (mq.size() != DEPTH));
    end
    pacc  = pv && (mq.size() != DEPTH);
    racc  = rv && (mq.size() != 0);
    exp_v = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rv && mq.size() == 0) m_err = 1'b1;
      if (racc) begin
        e = mq.pop_front();
        x = '{ip: e.ip, taken: tk, hist: e.hist, misp: e.pred ^ tk};
        exp_q.push_back(x);
        exp_v = 1'b1;
        if (x.misp) begin
          mq.delete();
          pacc = 1'b0;
        end
      end
      if (pacc) mq.push_back('{ip: ip, pred: pr, hist: hs});
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bus.upd_valid !== exp_v) begin
      errors++;
      $display("FAIL upd_valid: got %b want %b", bus.upd_valid, exp_v);
    end
    if (exp_v) begin
      x = exp_q.pop_front();
      if (bus.upd_valid === 1'b1) begin
        checks++;
        if (bus.upd_ip !== x.ip || bus.upd_taken !== x.taken ||
            bus.upd_hist !== x.hist || bus.upd_mispredict !== x.misp) begin
          errors++;
          $display("FAIL upd_beat: got ip=%h tk=%b hist=%h misp=%b want ip=%h tk=%b hist=%h misp=%b",
                   bus.upd_ip, bus.upd_taken, bus.upd_hist, bus.upd_mispredict,
                   x.ip, x.taken, x.hist, x.misp);
        end
      end
    end
    checks++;
    if (bus.count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL count: got %0d want %0d", bus.count, mq.size());
    end
    checks++;
    if (bus.err_underflow !== m_err) begin
      errors++;
      $display("FAIL err_underflow: got %b want %b", bus.err_underflow, m_err);
    end
  endtask

  task automatic push(input logic [63:0] ip, input logic pr, input logic [7:0] hs);
    cycle(1'b1, ip, pr, hs, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic tk);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, tk, 1'b0);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.upd_valid !== 1'b0 || bus.upd_ip !== '0 || bus.upd_taken !== 1'b0 ||
        bus.upd_hist !== '0 || bus.upd_mispredict !== 1'b0 || bus.err_underflow !== 1'b0 ||
        bus.count !== '0 || bus.push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b ip=%h hist=%h err=%b cnt=%0d rdy=%b want all 0, rdy=1",
               bus.upd_valid, bus.upd_ip, bus.upd_hist, bus.err_underflow, bus.count, bus.push_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    push(64'h1000, 1'b1, 8'hA5);
    checks++;
    if (bus.count !== 4'd1) begin
      errors++;
      $display("FAIL single_count1: got %0d want 1", bus.count);
    end
    resolve(1'b1);
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_ip !== 64'h1000 || bus.upd_hist !== 8'hA5 ||
        bus.upd_taken !== 1'b1 || bus.upd_mispredict !== 1'b0 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL single_beat: got v=%b ip=%h hist=%h tk=%b misp=%b cnt=%0d want 1 1000 a5 1 0 0",
               bus.upd_valid, bus.upd_ip, bus.upd_hist, bus.upd_taken, bus.upd_mispredict, bus.count);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++)
      push(64'h2000 + 64'(i * 4), 1'(i % 2), 8'(8'h10 + i));
    checks++;
    if (bus.count !== 4'd8 || bus.push_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got cnt=%0d rdy=%b want 8 0", bus.count, bus.push_ready);
    end
    push(64'hDEAD, 1'b0, 8'hFF);
    // Resolve at full with a push attempt: ready stays low this cycle.
    cycle(1'b1, 64'hBEEF, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.push_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reopen: got rdy=%b want 1", bus.push_ready);
    end
    for (int i = 1; i < DEPTH; i++) resolve(1'(i % 2));
    checks++;
    if (bus.count !== 4'd0) begin
      errors++;
      $display("FAIL full_drain: got cnt=%0d want 0", bus.count);
    end
  endtask

  task automatic test_mispredict();
    push(64'h3000, 1'b0, 8'h01);
    push(64'h3004, 1'b1, 8'h02);
    push(64'h3008, 1'b1, 8'h03);
    cycle(1'b1, 64'h300C, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.upd_mispredict !== 1'b1 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL mispredict: got misp=%b cnt=%0d want 1 0", bus.upd_mispredict, bus.count);
    end
    // Resolve on empty with a same-cycle push: underflow, push retained.
    cycle(1'b1, 64'h3010, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.err_underflow !== 1'b1 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL misp_underflow: got err=%b cnt=%0d want 1 1", bus.err_underflow, bus.count);
    end
    resolve(1'b1);
  endtask

  task automatic test_push_resolve();
    push(64'h4000, 1'b1, 8'h11);
    push(64'h4004, 1'b0, 8'h22);
    cycle(1'b1, 64'h4008, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 4'd2 || bus.upd_valid !== 1'b1) begin
      errors++;
      $display("FAIL push_resolve: got cnt=%0d v=%b want 2 1", bus.count, bus.upd_valid);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    resolve(1'b0);
    resolve(1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) push(64'h5000 + 64'(i), 1'b1, 8'(i));
    cycle(1'b1, 64'h5100, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.count !== 4'd0 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: got cnt=%0d v=%b want 0 0", bus.count, bus.upd_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) push(64'h6000 + 64'(i * 8), 1'(i % 3 == 0), 8'($urandom_range(255)));
    for (int i = 0; i < 5; i++) resolve(1'(i % 3 == 0));
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_underflow_reset();
    resolve(1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    push(64'h7000, 1'b1, 8'h5A);
    push(64'h7004, 1'b1, 8'h5B);
    // Resolve pending at the next edge, but reset lands first.
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    m_err = 1'b0;
    checks++;
    if (bus.upd_valid !== 1'b0 || bus.upd_ip !== '0 || bus.upd_taken !== 1'b0 ||
        bus.upd_hist !== '0 || bus.upd_mispredict !== 1'b0 || bus.err_underflow !== 1'b0 ||
        bus.count !== '0 || bus.push_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b ip=%h err=%b cnt=%0d rdy=%b want 0 0 0 0 1",
               bus.upd_valid, bus.upd_ip, bus.err_underflow, bus.count, bus.push_ready);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_beat: got v=%b want 0", bus.upd_valid);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push(64'h8000, 1'b0, 8'h99);
    resolve(1'b0);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_mispredict();
    test_push_resolve();
    test_flush();
    test_back_to_back();
    test_underflow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
